// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: MEM-stage controls plus data-memory req/ack bus seen by the load/store unit
interface mem_stage_lsu_if;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    logic        BusErr_M;
    logic        MisalignErr_M;
    modport slave (
        input  MemRead_M, MemWrite_M, funct3_M, ALUResult_M, WriteData_M, dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, ReadData_M, Stall_M, BusErr_M,
               MisalignErr_M
    );
    modport master (
        output MemRead_M, MemWrite_M, funct3_M, ALUResult_M, WriteData_M, dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, ReadData_M, Stall_M, BusErr_M,
               MisalignErr_M
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/ack bus, timeout abort; MISALIGN_TRAP_EN enables misalignment trap
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            reset,
    mem_stage_lsu_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req, r_we, r_err;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [3:0]    r_wstrb;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic          w_access, w_mis, w_go;
    logic [1:0]    w_off;
    logic [31:0]   w_wdata, w_ld;
    logic [3:0]    w_wstrb;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    assign w_access = bus.MemRead_M | bus.MemWrite_M;
    assign w_off    = bus.ALUResult_M[1:0];
    assign w_wdata  = bus.funct3_M[1] ? bus.WriteData_M :
                      bus.funct3_M[0] ? {2{bus.WriteData_M[15:0]}} : {4{bus.WriteData_M[7:0]}};
    assign w_wstrb  = !bus.MemWrite_M ? 4'b0000 :
                      bus.funct3_M[1] ? 4'b1111 :
                      bus.funct3_M[0] ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << w_off;
    assign w_byte   = bus.dmem_rdata[{r_off, 3'b000} +: 8];
    assign w_half   = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    assign w_ld     = r_f3[1] ? bus.dmem_rdata :
                      r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half} :
                                {{24{~r_f3[2] & w_byte[7]}}, w_byte};
`ifdef MISALIGN_TRAP_EN
    assign w_mis = w_access && r_state == IDLE &&
                   (bus.funct3_M[1] ? |w_off : bus.funct3_M[0] & w_off[0]);
`else
    assign w_mis = 1'b0;
`endif
    assign w_go              = r_state == IDLE && w_access && !w_mis;
    assign bus.Stall_M       = w_go | (r_state == REQ);
    assign bus.MisalignErr_M = w_mis;
    assign bus.dmem_req      = r_req;
    assign bus.dmem_we       = r_we;
    assign bus.dmem_addr     = r_addr;
    assign bus.dmem_wdata    = r_wdata;
    assign bus.dmem_wstrb    = r_wstrb;
    assign bus.ReadData_M    = r_rdata;
    assign bus.BusErr_M      = r_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wstrb <= '0;
            r_f3    <= '0;
            r_off   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_go) begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    r_we    <= bus.MemWrite_M;
                    r_addr  <= {bus.ALUResult_M[31:2], 2'b00};
                    r_wdata <= w_wdata;
                    r_wstrb <= w_wstrb;
                    r_f3    <= bus.funct3_M;
                    r_off   <= w_off;
                end
                REQ: if (bus.dmem_ack) begin
                    r_state <= DONE;
                    r_req   <= 1'b0;
                    if (!r_we) r_rdata <= w_ld;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= DONE;
                    r_req   <= 1'b0;
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed plus randomized checks of mem_stage_lsu against an arithmetic reference model
module tb_mem_stage_lsu;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rd = '0;
    mem_stage_lsu_if bus();
    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return f3[1] ? 4 : f3[0] ? 2 : 1;
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input int off, input logic [31:0] rd);
        int sz, sh;
        longint v;
        sz = size_of(f3);
        if (sz == 4) return rd;
        sh = sz == 1 ? off : (off / 2) * 2;
        v = longint'(rd >> (8 * sh)) % (64'sd1 << (8 * sz));
        if (!f3[2] && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input int off);
`ifdef MISALIGN_TRAP_EN
        return (size_of(f3) == 2 && off % 2 == 1) || (size_of(f3) == 4 && off != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_stall"}, 32'(bus.Stall_M), 32'd0);
        chk({tag, "_req"}, 32'(bus.dmem_req), 32'd0);
        chk({tag, "_buserr"}, 32'(bus.BusErr_M), 32'd0);
        chk({tag, "_rdata"}, bus.ReadData_M, exp_rd);
        @(posedge clk); #1;
    endtask

    task automatic xact(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int dly);
        int sz, off;
        logic [3:0] strb;
        logic [31:0] wexp;
        logic acked;
        sz = size_of(f3);
        off = int'(addr[1:0]);
        strb = !wr ? 4'd0 : sz == 1 ? 4'(1 << off) : sz == 2 ? 4'(3 << ((off / 2) * 2)) : 4'hf;
        wexp = sz == 1 ? (wd & 32'hff) * 32'h01010101 : sz == 2 ? (wd & 32'hffff) * 32'h00010001 : wd;
        acked = 1'b0;
        bus.MemRead_M = rd; bus.MemWrite_M = wr; bus.funct3_M = f3;
        bus.ALUResult_M = addr; bus.WriteData_M = wd;
        @(negedge clk);
        if (is_mis(f3, off)) begin
            chk({tag, "_miserr"}, 32'(bus.MisalignErr_M), 32'd1);
            chk({tag, "_mis_stall"}, 32'(bus.Stall_M), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_mis_req"}, 32'(bus.dmem_req), 32'd0);
            chk({tag, "_mis_rdata"}, bus.ReadData_M, exp_rd);
        end else begin
            chk({tag, "_miserr0"}, 32'(bus.MisalignErr_M), 32'd0);
            chk({tag, "_stall_idle"}, 32'(bus.Stall_M), 32'd1);
            @(posedge clk); #1;
            chk({tag, "_addr"}, bus.dmem_addr, addr & 32'hffff_fffc);
            chk({tag, "_we"}, 32'(bus.dmem_we), 32'(wr));
            chk({tag, "_wstrb"}, 32'(bus.dmem_wstrb), 32'(strb));
            if (wr) chk({tag, "_wdata"}, bus.dmem_wdata, wexp);
            for (int k = 0; k < TO; k++) begin
                chk({tag, "_req"}, 32'(bus.dmem_req), 32'd1);
                if (k == dly) begin
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = rdata;
                    acked = 1'b1;
                end
                @(negedge clk);
                chk({tag, "_stall_req"}, 32'(bus.Stall_M), 32'd1);
                @(posedge clk); #1;
                bus.dmem_ack = 1'b0;
                if (acked) break;
            end
            if (!acked) exp_rd = '0;
            else if (!wr) exp_rd = ld_model(f3, off, rdata);
            @(negedge clk);
            chk({tag, "_stall_done"}, 32'(bus.Stall_M), 32'd0);
            chk({tag, "_req_done"}, 32'(bus.dmem_req), 32'd0);
            chk({tag, "_buserr"}, 32'(bus.BusErr_M), 32'(!acked));
            chk({tag, "_rdata"}, bus.ReadData_M, exp_rd);
            @(posedge clk); #1;
        end
        bus.MemRead_M = 1'b0; bus.MemWrite_M = 1'b0;
    endtask

    initial begin
        logic [2:0] a;
        bus.MemRead_M = 1'b0; bus.MemWrite_M = 1'b0; bus.funct3_M = '0;
        bus.ALUResult_M = '0; bus.WriteData_M = '0; bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_rdata", bus.ReadData_M, 32'd0);
        chk("rst_stall", 32'(bus.Stall_M), 32'd0);
        chk("rst_wstrb", 32'(bus.dmem_wstrb), 32'd0);
        chk("rst_buserr", 32'(bus.BusErr_M), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        idle_check("stale_ack");
        bus.dmem_ack = 1'b0;
        xact("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        chk("lw_val", exp_rd, 32'hDEADBEEF);
        idle_check("hold");
        xact("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 1);
        chk("lb_val", exp_rd, 32'hFFFFFF80);
        xact("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80FF_0000, 0);
        chk("lbu_val", exp_rd, 32'h00000080);
        xact("lh", 1, 0, 3'b001, 32'h102, 0, 32'h80FF_0000, 2);
        chk("lh_val", exp_rd, 32'hFFFF80FF);
        xact("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0);
        xact("sh", 0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0);
        xact("both", 1, 1, 3'b010, 32'h204, 32'h11223344, 32'h55667788, 0);
        xact("tmo", 1, 0, 3'b010, 32'h300, 0, 32'h12345678, 99);
        chk("tmo_val", exp_rd, 32'h0);
        idle_check("tmo_after");
        xact("lw_mis", 1, 0, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0);
        idle_check("mis_after");
        bus.MemRead_M = 1'b1; bus.funct3_M = 3'b010; bus.ALUResult_M = 32'h300;
        @(posedge clk); #1;
        chk("rstmid_req1", 32'(bus.dmem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.MemRead_M = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        exp_rd = '0;
        @(negedge clk);
        chk("rstmid_req", 32'(bus.dmem_req), 32'd0);
        chk("rstmid_addr", bus.dmem_addr, 32'd0);
        chk("rstmid_we", 32'(bus.dmem_we), 32'd0);
        chk("rstmid_rdata", bus.ReadData_M, 32'd0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        idle_check("rstmid_ack_ignored");
        for (int i = 0; i < 40; i++) begin
            a = 3'($urandom_range(1, 3));
            xact("rnd", a[0], a[1], 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
        end
        idle_check("end");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the 5-stage RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns MEM-stage load/store controls into a req/ack data-memory bus transaction, with byte-lane strobes and load sign/zero extension.
- Holds the pipeline via Stall_M until the access completes; ReadData_M feeds the MEM/WB register directly.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in REQ without dmem_ack before the access is aborted (must be ≥1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- MemRead_M  in  1  load in MEM stage
- MemWrite_M  in  1  store in MEM stage
- funct3_M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResult_M  in  32  byte address
- WriteData_M  in  32  store data, right-justified
- dmem_rdata  in  32  bus read word
- dmem_ack  in  1  bus completion, 1-cycle pulse
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  bus write enable, registered
- dmem_addr  out  32  word address ({addr[31:2],2'b00}), registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_wstrb  out  4  byte strobes, registered
- ReadData_M  out  32  formatted load result, registered
- Stall_M  out  1  holds PC, IF/ID, ID/EX, EX/MEM; combinational
- BusErr_M  out  1  timeout abort flag, registered
- MisalignErr_M  out  1  misaligned access flag, combinational

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; timeout counter 0.
- access = MemRead_M | MemWrite_M. If both are high, the access is treated as a store.
- States:
  - IDLE: on access, latch dmem_addr/we/wdata/wstrb, set dmem_req=1, go REQ. With no access, Stall_M=0 and ReadData_M holds its value.
  - REQ: dmem_req stays 1 and bus outputs are stable until dmem_ack.
    - On ack: dmem_req←0; loads capture the formatted dmem_rdata into ReadData_M; go DONE.
    - Counter increments each REQ cycle. If it reaches TIMEOUT_CYCLES with no ack: dmem_req←0, BusErr_M←1, ReadData_M←0, go DONE.
  - DONE: Stall_M=0 so the pipeline advances and MEM/WB captures ReadData_M. BusErr_M is valid this cycle only. Counter clears; next state IDLE unconditionally.
- Stall_M = (IDLE & access & ~misalign_block) | REQ.
- Latency with ack in the first REQ cycle: 2 stall cycles plus the DONE cycle.
- Back-to-back accesses: the new instruction is seen in IDLE the cycle after DONE; no bubble insertion beyond that.
- dmem_ack in IDLE or DONE is ignored (covers a stale ack after reset).
- Store format (lane off = addr[1:0]):
  - SB: wdata = {4{WriteData_M[7:0]}}, wstrb = 0001<<off.
  - SH: wdata = {2{WriteData_M[15:0]}}, wstrb = 0011<<(2*addr[1]).
  - SW: wdata = WriteData_M, wstrb = 1111.
  - Loads: wstrb = 0000.
- Load format:
  - B/BU select byte off; H/HU select half addr[1]; W is the full word.
  - B/H sign-extend; BU/HU zero-extend.
- funct3 011, 110, 111 are treated as W.
- Reset mid-transaction: dmem_req drops at that edge, FSM→IDLE, no write of ReadData_M.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Misaligned access in IDLE: MisalignErr_M=1 combinationally, no bus request, Stall_M=0, ReadData_M unchanged, FSM stays IDLE.
- Undefined:
  - MisalignErr_M tied 0.
  - Low address bits below access size are ignored (H uses addr[1], W uses the aligned word).

Test Plan:
- LW addr 0x100, ack on first REQ cycle with rdata 0xDEADBEEF → dmem_addr 0x100, wstrb 0000, Stall_M high 2 cycles, ReadData_M=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF_0000 → ReadData_M=0xFFFFFF80. Same access as LBU → 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB data 0x000000A5 addr 0x201 → dmem_we=1, wdata 0xA5A5A5A5, wstrb 0010. SH addr 0x202 data 0x1234 → wdata 0x12341234, wstrb 1100.
- No ack, TIMEOUT_CYCLES=4 → dmem_req drops after 4 REQ cycles, BusErr_M=1 for 1 cycle, ReadData_M=0, Stall_M released.
- Reset asserted in REQ, then ack next cycle → dmem_req=0, FSM IDLE, ack ignored, all outputs 0.
- MISALIGN_TRAP_EN defined, LW addr 0x102 → MisalignErr_M=1, dmem_req never asserts, Stall_M=0. Undefined: dmem_addr 0x100, normal load.
